// File: rtl/interpolate.sv
// Upsampler: takes one sample through a 2-deep FIFO and emits INTERP_FACTOR
// output strobes per sample, spaced OUT_PERIOD cycles, zero-stuffed or held.
module interpolate #(
   parameter int INTERP_FACTOR = 4,
   parameter int WIDTH         = 16,
   parameter int OUT_PERIOD    = 4,
   parameter int HOLD_MODE     = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic signed [WIDTH-1:0] data_in,
   output logic                    valid_out,
   output logic signed [WIDTH-1:0] data_out,
   output logic                    busy
);

   localparam int TW = $clog2(OUT_PERIOD) + 1;
   localparam int PW = $clog2(INTERP_FACTOR) + 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(OUT_PERIOD - 1);
   localparam logic [TW-1:0] TICK_START = (OUT_PERIOD == 1) ? '0 : TW'(1);
   localparam logic [PW-1:0] PH_LAST    = PW'(INTERP_FACTOR - 1);
   localparam logic [PW-1:0] PH_AFTER0  = (INTERP_FACTOR == 1) ? '0 : PW'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                    state, state_nxt;
   logic [TW-1:0]             tick, tick_nxt;
   logic [PW-1:0]             phase, phase_nxt;
   logic signed [WIDTH-1:0]   cur_sample, cur_nxt, dout_nxt;
   logic                      vout_nxt;

   logic signed [WIDTH-1:0]   mem [2];
   logic                      wr_ptr, rd_ptr;
   logic [1:0]                count;
   logic                      push, pop;

   // ready depends only on registered count, forced low while in reset
   assign ready_in = rst & (count < 2'd2);
   assign push     = valid_in & ready_in;
   assign busy     = (state == RUN);

   always_comb begin
      state_nxt = state;
      tick_nxt  = tick;
      phase_nxt = phase;
      cur_nxt   = cur_sample;
      dout_nxt  = data_out;
      vout_nxt  = 1'b0;
      pop       = 1'b0;
      if (state == IDLE) begin
         if (count != 2'd0) begin
            state_nxt = RUN;
            tick_nxt  = TICK_START;
            pop       = 1'b1;
         end
      end else begin
         tick_nxt = (tick == TICK_LAST) ? '0 : tick + 1'b1;
         if (tick == '0) begin
            if (phase == '0) begin
               if (count != 2'd0) begin
                  pop = 1'b1;
               end else begin
                  // end of stream: fall back to IDLE with no output
                  state_nxt = IDLE;
                  tick_nxt  = '0;
               end
            end else begin
               dout_nxt  = (HOLD_MODE != 0) ? cur_sample : '0;
               vout_nxt  = 1'b1;
               phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
         end
      end
      if (pop) begin
         cur_nxt   = mem[rd_ptr];
         dout_nxt  = mem[rd_ptr];
         vout_nxt  = 1'b1;
         phase_nxt = PH_AFTER0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         tick       <= '0;
         phase      <= '0;
         cur_sample <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
      end else begin
         state      <= state_nxt;
         tick       <= tick_nxt;
         phase      <= phase_nxt;
         cur_sample <= cur_nxt;
         data_out   <= dout_nxt;
         valid_out  <= vout_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // storage needs no reset; count=0 already marks it empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: tb/tb_interpolate.sv
// Directed bench for interpolate: zero-stuff, hold, streaming with
// backpressure, L=1 pass-through and asynchronous reset mid-group.
module tb_interpolate;

   logic clk = 1'b0;
   logic rst;

   logic v0, r0, vo0, b0;
   logic [15:0] d0, do0;
   logic v1, r1, vo1, b1;
   logic [15:0] d1, do1;
   logic v2, r2, vo2, b2;
   logic [15:0] d2, do2;

   int n_vec = 0;
   int n_err = 0;
   int acc, pulses, last, mcount;
   logic exp_push, exp_v;

   always #5 clk = ~clk;

   interpolate #(.INTERP_FACTOR(4), .WIDTH(16), .OUT_PERIOD(4), .HOLD_MODE(0)) u_zs (
      .clk(clk), .rst(rst), .valid_in(v0), .ready_in(r0), .data_in(d0),
      .valid_out(vo0), .data_out(do0), .busy(b0));

   interpolate #(.INTERP_FACTOR(4), .WIDTH(16), .OUT_PERIOD(4), .HOLD_MODE(1)) u_hold (
      .clk(clk), .rst(rst), .valid_in(v1), .ready_in(r1), .data_in(d1),
      .valid_out(vo1), .data_out(do1), .busy(b1));

   interpolate #(.INTERP_FACTOR(1), .WIDTH(16), .OUT_PERIOD(1), .HOLD_MODE(0)) u_l1 (
      .clk(clk), .rst(rst), .valid_in(v2), .ready_in(r2), .data_in(d2),
      .valid_out(vo2), .data_out(do2), .busy(b2));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
      n_vec++;
      assert (obs === exp_val) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_val);
      end
   endtask

   initial begin
      rst = 1'b0;
      v0 = 1'b0; d0 = '0;
      v1 = 1'b0; d1 = '0;
      v2 = 1'b0; d2 = '0;
      #3;
      chk("rst_ready0", r0, 0);
      chk("rst_vout0", vo0, 0);
      chk("rst_dout0", do0, 0);
      chk("rst_busy0", b0, 0);
      chk("rst_ready2", r2, 0);
      step();
      step();
      rst = 1'b1;
      step();
      chk("idle_ready0", r0, 1);
      chk("idle_ready1", r1, 1);

      // single sample: zero-stuff on u_zs, hold on u_hold
      v0 = 1'b1; d0 = 16'h1234;
      v1 = 1'b1; d1 = 16'hFFFB;
      step();
      v0 = 1'b0; v1 = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         step();
         exp_v = (n == 1) || (n == 5) || (n == 9) || (n == 13);
         chk("zs_vout", vo0, exp_v);
         chk("zs_dout", do0, (n < 5) ? 16'h1234 : 16'h0000);
         chk("zs_busy", b0, n <= 16);
         chk("hold_vout", vo1, exp_v);
         chk("hold_dout", do1, 16'hFFFB);
      end

      // back-to-back stream of 1..8 with valid held high
      acc = 0; mcount = 0; pulses = 0; last = 0;
      for (int cyc = 0; cyc < 200 && pulses < 32; cyc++) begin
         v0 = (acc < 8);
         d0 = 16'(acc + 1);
         chk("stream_ready", r0, mcount < 2);
         exp_push = v0 && (mcount < 2);
         step();
         if (exp_push) begin
            acc++;
            mcount++;
         end
         if (vo0) begin
            if (pulses % 4 == 0) mcount--;
            chk("stream_data", do0, (pulses % 4 == 0) ? 32'(pulses / 4 + 1) : 32'd0);
            if (pulses > 0) chk("stream_gap", cyc - last, 4);
            last = cyc;
            pulses++;
         end
      end
      v0 = 1'b0;
      chk("stream_pulses", pulses, 32);
      chk("stream_accepted", acc, 8);
      for (int n = 1; n <= 6; n++) begin
         step();
         chk("stream_tail_vout", vo0, 0);
      end
      chk("stream_tail_busy", b0, 0);

      // L=1, OUT_PERIOD=1: one output every cycle
      for (int k = 1; k <= 12; k++) begin
         v2 = (k <= 10);
         d2 = 16'(16'h0100 + k);
         if (k <= 10) chk("l1_ready", r2, 1);
         step();
         if (k >= 2) chk("l1_vout", vo2, k <= 11);
         if (k >= 2 && k <= 11) chk("l1_dout", do2, 32'(16'h0100 + k - 1));
      end
      v2 = 1'b0;
      chk("l1_busy_end", b2, 0);

      // async reset in the middle of a hold group
      v1 = 1'b1; d1 = 16'h55AA;
      step();
      v1 = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         step();
         if (n == 2) chk("mid_gap_vout", vo1, 0);
      end
      chk("mid_vout", vo1, 1);
      chk("mid_dout", do1, 16'h55AA);
      chk("mid_busy", b1, 1);
      rst = 1'b0;
      #1;
      chk("arst_vout", vo1, 0);
      chk("arst_dout", do1, 0);
      chk("arst_busy", b1, 0);
      chk("arst_ready", r1, 0);
      step();
      step();
      rst = 1'b1;
      #1;
      chk("rel_ready", r1, 1);
      chk("rel_busy", b1, 0);
      step();
      chk("rel_no_resume", vo1, 0);
      chk("rel_idle", b1, 0);
      v1 = 1'b1; d1 = 16'h0007;
      step();
      v1 = 1'b0;
      step();
      chk("restart_vout", vo1, 1);
      chk("restart_dout", do1, 16'h0007);
      chk("restart_busy", b1, 1);
      step();
      chk("restart_gap", vo1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
